clock_divider_multi: RTL and testbench
======================================

# clock_divider_multi

Parametrised, runtime-programmable multi-channel clock divider. Each of CHANNELS channels divides `clk` by 2 × its divisor, producing a square-wave `sclk` and single-cycle rise/fall enable strobes. Divisor changes are applied only on half-period boundaries, so outputs never glitch. The block sits beside the MCU core, driving slow peripheral clocks and enables: display multiplexing, debounce sampling and the multicycle step clock.

## Interface
Parameters:
- CHANNELS, 4, number of independent divider channels (1..16)
- WIDTH, 16, divisor width in bits
- RESET_DIV, 1, divisor loaded into every channel by reset (0..2^WIDTH-1)

Ports:
- clk  input  1  system clock, all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- cfg_we  input  1  divisor write strobe, one cycle per write
- cfg_sel  input  $clog2(CHANNELS) (min 1)  target channel of the write
- cfg_div  input  WIDTH  new divisor; 0 = stop channel
- sync  input  1  restarts all channels in phase
- sclk  output  CHANNELS  divided clock per channel, registered
- rise_tick  output  CHANNELS  one-cycle pulse, coincident with sclk going 1
- fall_tick  output  CHANNELS  one-cycle pulse, coincident with sclk going 0
- pending  output  CHANNELS  1 while a written divisor awaits its boundary

## Operation
- Per-channel state: cnt (WIDTH), div_cur (WIDTH), div_pend (WIDTH), pend_v, sclk.
- Running (div_cur ≠ 0): cnt increments each cycle. When cnt == div_cur−1, sclk toggles, cnt clears, the matching tick asserts, and div_cur ← div_pend if pend_v (pend_v clears). Output frequency = clk / (2 × div_cur), duty exactly 50%.
- Stopped (div_cur == 0): sclk held 0, cnt held 0, no ticks. A pending non-zero divisor is adopted on the next cycle, and counting starts from cnt = 0.
- Write of 0 to a running channel: adopted at the next boundary. If that boundary is the falling edge, the channel stops low. If it is the rising edge, sclk still goes high, that half-period completes at the old divisor, then sclk falls and the channel stops.
- cfg_we: div_pend[cfg_sel] ← cfg_div and pend_v ← 1. A second write before the boundary overwrites the first (last write wins). A write with cfg_sel ≥ CHANNELS is ignored.
- Write on a boundary cycle of the same channel: the boundary adopts the previous pending value, if any. The new write stays pending.
- sync: every channel gets cnt ← 0 and sclk ← 0, with no fall_tick. Any pending value, including a same-cycle write, is adopted immediately.
- rst has priority over sync and cfg_we.

## Timing
- Reset values: sclk = 0, rise_tick = 0, fall_tick = 0, pending = 0. Internally cnt = 0, div_cur = RESET_DIV, pend_v = 0.
- With rst deasserted before edge 0, the first sclk rise and rise_tick appear after edge div_cur−1, i.e. sclk is 1 for the first time in cycle div_cur. Later toggles follow every div_cur cycles.
- Divisor 1 gives sclk toggling every cycle (clk/2), with ticks alternating rise and fall.
- Write latency: pending goes high the cycle after cfg_we and low the cycle after adoption.
- rst mid-period: all channels return to reset values on the next edge, and pending writes are lost.
- Ticks are registered outputs, never combinational from inputs.

## Structure
- Package clock_divider_pkg: CH_IDX_W helper function (max(1, $clog2(n))) and the chan_cfg_t struct {div, valid}.
- Sub-module clock_divider_channel: one channel's counter, divisor registers and tick logic. The top level generates CHANNELS instances and decodes cfg_sel.
- The top level holds no state beyond the write decode.

## Test plan
- Reset release, RESET_DIV=3, CHANNELS=2 → both sclk rise at cycle 3 and fall at cycle 6; rise_tick at cycles 3, 9, 15; no fall_tick before cycle 6.
- Write div=5 to ch1 mid-high-phase (old div 3) → current high phase completes at 3 cycles, then the low phase is 5 cycles; pending high for exactly that interval; ch0 unaffected.
- Write 0 to running ch0 while it is low → ch0 rises at the boundary, stays high 3 cycles, falls, then stays 0 with no further ticks. Then write 2 → sclk rises 2 cycles after adoption.
- Two writes (4, then 7) to ch1 before a boundary → 7 is adopted and 4 never appears. A write with cfg_sel=3 when CHANNELS=2 → no state changes.
- sync asserted with channels at different phases → all sclk 0 next cycle with no fall_tick, then identical waveforms. A same-cycle write to ch0 is applied immediately.
- rst pulsed mid-period with a pending write → outputs return to reset values, and the pending write is discarded.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clock_divider_pkg;

    // Widest divisor a channel write can carry; channels use the low WIDTH bits.
    localparam int CFG_DIV_W = 32;

    // One channel's write request as decoded by the top level.
    typedef struct packed {
        logic [CFG_DIV_W-1:0] div;
        logic                 valid;
    } chan_cfg_t;

    // Channel-select width: at least one bit even for a single channel.
    function automatic int CH_IDX_W(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: half-period counter, current/pending divisor and
// registered rise/fall strobes. Divisor changes land only on half-period
// boundaries so sclk never glitches.
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  chan_cfg_t wr_cfg,
    input  logic      sync,
    output logic      sclk,
    output logic      rise_tick,
    output logic      fall_tick,
    output logic      pending
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_cur_q, div_cur_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    logic             pend_v_q, pend_v_d;
    logic             sclk_q, sclk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    logic [WIDTH-1:0] wr_div;
    logic             boundary;
    logic             defer_stop;

    assign wr_div = wr_cfg.div[WIDTH-1:0];

    // Bits above WIDTH are never meaningful for this channel.
    if (WIDTH < CFG_DIV_W) begin : g_div_hi
        logic unused_div_hi;
        assign unused_div_hi = |wr_cfg.div[CFG_DIV_W-1:WIDTH];
    end

    // Next-state: sync realigns, stopped channels adopt at once, running ones at boundaries.
    always_comb begin
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pend_v_d   = pend_v_q;
        sclk_d     = sclk_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        boundary   = (div_cur_q != '0) && (cnt_q == div_cur_q - WIDTH'(1));
        // A stop request reaching a rising boundary waits out the high phase
        // so the last pulse keeps its full width.
        defer_stop = pend_v_q && (div_pend_q == '0) && !sclk_q;

        if (sync) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
            if (wr_cfg.valid) begin
                div_cur_d  = wr_div;
                div_pend_d = wr_div;
                pend_v_d   = 1'b0;
            end else if (pend_v_q) begin
                div_cur_d = div_pend_q;
                pend_v_d  = 1'b0;
            end
        end else begin
            if (div_cur_q == '0) begin
                cnt_d  = '0;
                sclk_d = 1'b0;
                if (pend_v_q) begin
                    div_cur_d = div_pend_q;
                    pend_v_d  = 1'b0;
                end
            end else if (boundary) begin
                cnt_d  = '0;
                sclk_d = !sclk_q;
                rise_d = !sclk_q;
                fall_d = sclk_q;
                if (pend_v_q && !defer_stop) begin
                    div_cur_d = div_pend_q;
                    pend_v_d  = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
            // A write in the same cycle lands after any adoption: it stays pending.
            if (wr_cfg.valid) begin
                div_pend_d = wr_div;
                pend_v_d   = 1'b1;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            div_cur_q  <= WIDTH'(RESET_DIV);
            div_pend_q <= '0;
            pend_v_q   <= 1'b0;
            sclk_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_cur_q  <= div_cur_d;
            div_pend_q <= div_pend_d;
            pend_v_q   <= pend_v_d;
            sclk_q     <= sclk_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign sclk      = sclk_q;
    assign rise_tick = rise_q;
    assign fall_tick = fall_q;
    assign pending   = pend_v_q;

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel runtime-programmable clock divider. Holds no state of its own:
// it decodes the divisor write port and fans out to one channel per output.
//
// Write port: cfg_we is a one-cycle strobe with no ready; every strobe is
// accepted. cfg_sel values at or above CHANNELS address nothing and are dropped.
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           cfg_we,
    input  logic [CH_IDX_W(CHANNELS)-1:0]  cfg_sel,
    input  logic [WIDTH-1:0]               cfg_div,
    input  logic                           sync,
    output logic [CHANNELS-1:0]            sclk,
    output logic [CHANNELS-1:0]            rise_tick,
    output logic [CHANNELS-1:0]            fall_tick,
    output logic [CHANNELS-1:0]            pending
);

    localparam int SEL_W = CH_IDX_W(CHANNELS);

    chan_cfg_t wr_cfg [CHANNELS];

    // Decode the write strobe into a per-channel request.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wr_cfg[i].div   = CFG_DIV_W'(cfg_div);
            wr_cfg[i].valid = cfg_we && (cfg_sel == SEL_W'(i));
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        clock_divider_channel #(
            .WIDTH     (WIDTH),
            .RESET_DIV (RESET_DIV)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .wr_cfg    (wr_cfg[g]),
            .sync      (sync),
            .sclk      (sclk[g]),
            .rise_tick (rise_tick[g]),
            .fall_tick (fall_tick[g]),
            .pending   (pending[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi: three channels, 8-bit divisors, reset divisor 3.
// Tick events are hand-tabulated per channel and checked by a negedge monitor.
module tb_clock_divider_multi;

    localparam int CH = 3;
    localparam int W  = 23;  // {cycle[15:0], ch[3:0], rise, fall, sclk}

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic [7:0]    cfg_div;
    logic          sync;
    logic [CH-1:0] sclk;
    logic [CH-1:0] rise_tick;
    logic [CH-1:0] fall_tick;
    logic [CH-1:0] pending;

    int cyc   = 0;
    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b1;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_got;
    logic [W-1:0] mon_exp;

    clock_divider_multi #(
        .CHANNELS  (CH),
        .WIDTH     (8),
        .RESET_DIV (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_div   (cfg_div),
        .sync      (sync),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .pending   (pending)
    );

    // Clock and edge counter: edge k leaves cyc == k.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected tick events, per channel: +n = rise after edge n, -n = fall.
    int t0 [23] = '{6, -9, 12, -15, 18, -21, 24, -27, 33, -35, 37, -39, 41, -43,
                    45, -47, 49, 53, -56, 60, -63, 66, -69};
    int t1 [16] = '{6, -9, 12, -15, 20, -25, 30, -35, 42, -49, 53, -56, 60, -63, 66, -69};
    int t2 [21] = '{6, -9, 12, -15, 18, -21, 24, -27, 30, -33, 36, -39, 42, -45,
                    48, 53, -56, 60, -63, 66, -69};

    task automatic push_exp(input int c, input int ch);
        logic [W-1:0] e;
        bit           r;
        int           idx;
        r   = (c > 0);
        e   = {16'(r ? c : -c), 4'(ch), r, !r, r};
        idx = exp_q.size();
        while (idx > 0 && exp_q[idx-1] > e) idx--;
        exp_q.insert(idx, e);
    endtask

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, expv);
        end
    endtask

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_wr(input int ch, input int d);
        cfg_we  = 1'b1;
        cfg_sel = 2'(ch);
        cfg_div = 8'(d);
    endtask

    task automatic drive_idle();
        cfg_we  = 1'b0;
        cfg_sel = 2'd0;
        cfg_div = 8'd0;
        sync    = 1'b0;
    endtask

    // Monitor: flags overdue expectations, then compares every tick seen.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && int'(exp_q[0][22:7]) < cyc) begin
                mon_exp = exp_q.pop_front();
                n_cmp++;
                n_bad++;
                $display("FAIL missed_tick at cycle %0d: got none expected %h", cyc, mon_exp);
            end
            for (int ch = 0; ch < CH; ch++) begin
                if (rise_tick[ch] || fall_tick[ch]) begin
                    mon_got = {16'(cyc), 4'(ch), rise_tick[ch], fall_tick[ch], sclk[ch]};
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL extra_tick: got %h expected none", mon_got);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_got !== mon_exp) begin
                            n_bad++;
                            $display("FAIL tick: got %h expected %h", mon_got, mon_exp);
                        end
                    end
                end
            end
        end
    end

    // Directed stimulus with pending/level checks at fixed cycles.
    initial begin
        rst = 1'b1;
        drive_idle();
        foreach (t0[i]) push_exp(t0[i], 0);
        foreach (t1[i]) push_exp(t1[i], 1);
        foreach (t2[i]) push_exp(t2[i], 2);

        go_to(2);
        chk("reset_outputs", {4'h0, sclk, rise_tick, fall_tick, pending}, 16'h0);
        go_to(3);
        rst = 1'b0;

        // div 5 into ch1 during its high phase (rose at 12, falls at 15).
        go_to(12); drive_wr(1, 5);
        go_to(13); drive_idle(); chk("pend_ch1_a", 16'(pending), 16'b010);
        go_to(14); chk("pend_ch1_b", 16'(pending), 16'b010);
        go_to(15); chk("pend_ch1_clr", 16'(pending), 16'b000);

        // Stop ch0 while low; it still completes one full high phase.
        go_to(21); drive_wr(0, 0);
        go_to(22); drive_idle(); chk("pend_stop_a", 16'(pending), 16'b001);
        go_to(26); chk("pend_stop_b", 16'(pending), 16'b001);
        go_to(27); chk("pend_stop_clr", 16'(pending), 16'b000);
        go_to(29); chk("ch0_stopped", 16'(sclk[0]), 16'd0);
        drive_wr(0, 2);
        go_to(30); drive_wr(1, 4); chk("pend_restart", 16'(pending), 16'b001);
        go_to(31); drive_wr(1, 7); chk("pend_w4", 16'(pending), 16'b010);
        go_to(32); drive_wr(3, 1); chk("pend_w7", 16'(pending), 16'b010);
        go_to(33); drive_idle(); chk("bad_sel_ignored", 16'(pending), 16'b010);
        go_to(35); chk("pend_w7_clr", 16'(pending), 16'b000);

        // Write on ch1's boundary cycle stays pending; then sync with a ch0 write.
        go_to(48); drive_wr(1, 3);
        go_to(49); drive_wr(0, 3); sync = 1'b1;
        chk("pend_on_boundary", 16'(pending), 16'b010);
        go_to(50); drive_idle();
        chk("sync_state", {4'h0, sclk, fall_tick, rise_tick, pending}, 16'h0);

        // Pending write lost to a mid-period reset.
        go_to(53); drive_wr(2, 5);
        go_to(54); drive_idle(); chk("pend_ch2", 16'(pending), 16'b100);
        go_to(56); rst = 1'b1;
        go_to(57); rst = 1'b0;
        chk("rst_mid_outputs", {4'h0, sclk, rise_tick, fall_tick, pending}, 16'h0);
        go_to(58); chk("rst_pend_lost", 16'(pending), 16'b000);

        go_to(71);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("leftover_expected", 16'(exp_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
